// File: rtl/snn_result_pkg.sv
// Shared types and register map for the SNN result buffer.
// Holds the FSM state, read-port word offsets and status bit positions.
package snn_result_pkg;

  typedef enum logic [1:0] {
    IDLE,
    COUNT,
    SCAN,
    DONE
  } state_t;

  localparam int REG_STATUS   = 0;
  localparam int REG_WINNER   = 1;
  localparam int REG_WINCNT   = 2;
  localparam int REG_NOUT     = 3;
  localparam int REG_CNT_BASE = 4;

  localparam int ST_RDY  = 0;
  localparam int ST_BUSY = 1;
  localparam int ST_DONE = 2;
  localparam int ST_ERR  = 3;

endpackage

// File: rtl/snn_result_if.sv
// Spike-event handshake and register read port of the result buffer.
// master drives events/requests, slave is the buffer itself.
interface snn_result_if #(
  parameter int IDX_W  = 8,
  parameter int ADDR_W = 7
);
  logic              spike_valid;
  logic [IDX_W-1:0]  spike_idx;
  logic              spike_ready;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [31:0]       rd_data;
  logic              rd_valid;

  modport master (
    output spike_valid, spike_idx,
    output rd_en, rd_addr,
    input  spike_ready, rd_data, rd_valid
  );

  modport slave (
    input  spike_valid, spike_idx,
    input  rd_en, rd_addr,
    output spike_ready, rd_data, rd_valid
  );
endinterface

// File: rtl/snn_result_argmax.sv
// Sequential argmax: one count per cycle, strict greater-than,
// so ties resolve to the lowest index.
module snn_result_argmax #(
  parameter int N_OUT = 10,
  parameter int CNT_W = 16,
  parameter int IW    = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
  input  logic             ACLK,
  input  logic             ARESETN,
  input  logic             start,
  input  logic [CNT_W-1:0] cnt_in,
  output logic [IW-1:0]    idx,
  output logic [IW-1:0]    best_idx,
  output logic [CNT_W-1:0] best,
  output logic             done
);

  logic run;

  assign done = run && (idx == IW'(N_OUT - 1));

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      run      <= 1'b0;
      idx      <= '0;
      best     <= '0;
      best_idx <= '0;
    end else if (start) begin
      run      <= 1'b1;
      idx      <= '0;
      best     <= '0;
      best_idx <= '0;
    end else if (run) begin
      if (cnt_in > best) begin
        best     <= cnt_in;
        best_idx <= idx;
      end
      if (done) run <= 1'b0;
      else      idx <= idx + IW'(1);
    end
  end

endmodule

// File: rtl/snn_result_buffer.sv
// Per-class saturating spike counters, window FSM, argmax
// and a 1-cycle register read port for the AXI4-Lite slave.
module snn_result_buffer
  import snn_result_pkg::*;
#(
  parameter int N_OUT  = 10,
  parameter int CNT_W  = 16,
  parameter int IDX_W  = 8,
  parameter int ADDR_W = 7
) (
  input  logic         ACLK,
  input  logic         ARESETN,
  input  logic         infer_start,
  input  logic         infer_end,
  input  logic         result_ack,
  output logic         result_ready,
  output logic         busy,
  snn_result_if.slave  bus
);

  localparam int IW = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state;
  logic [CNT_W-1:0] counts [N_OUT];
  logic             err;
  logic             clr;
  logic             acc;
  logic             bad;
  logic             scan_start;
  logic             scan_done;
  logic [IW-1:0]    scan_idx;
  logic [IW-1:0]    win_idx;
  logic [CNT_W-1:0] win_cnt;
  logic [31:0]      stat;
  logic [31:0]      word;

  // A restart request outranks a simultaneous spike or window close.
  assign clr        = infer_start && (state != SCAN);
  assign acc        = (state == COUNT) && bus.spike_valid;
  assign bad        = 32'(bus.spike_idx) >= 32'(N_OUT);
  assign scan_start = (state == COUNT) && infer_end && !infer_start;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      for (int i = 0; i < N_OUT; i++) counts[i] <= '0;
      err <= 1'b0;
    end else if (clr) begin
      for (int i = 0; i < N_OUT; i++) counts[i] <= '0;
      err <= 1'b0;
    end else if (acc) begin
      if (bad) err <= 1'b1;
      for (int i = 0; i < N_OUT; i++) begin
        if (bus.spike_idx == IDX_W'(i) && counts[i] != CNT_MAX)
          counts[i] <= counts[i] + CNT_W'(1);
      end
    end
  end

  snn_result_argmax #(
    .N_OUT (N_OUT),
    .CNT_W (CNT_W),
    .IW    (IW)
  ) u_argmax (
    .ACLK     (ACLK),
    .ARESETN  (ARESETN),
    .start    (scan_start),
    .cnt_in   (counts[scan_idx]),
    .idx      (scan_idx),
    .best_idx (win_idx),
    .best     (win_cnt),
    .done     (scan_done)
  );

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state           <= IDLE;
      bus.spike_ready <= 1'b0;
      busy            <= 1'b0;
      result_ready    <= 1'b0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (infer_start) begin
            state           <= COUNT;
            bus.spike_ready <= 1'b1;
            busy            <= 1'b1;
            result_ready    <= 1'b0;
          end else if (state == DONE && result_ack) begin
            state        <= IDLE;
            result_ready <= 1'b0;
          end
        end
        COUNT: begin
          if (scan_start) begin
            state           <= SCAN;
            bus.spike_ready <= 1'b0;
          end
        end
        SCAN: begin
          if (scan_done) begin
            state        <= DONE;
            busy         <= 1'b0;
            result_ready <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    stat          = '0;
    stat[ST_RDY]  = result_ready;
    stat[ST_BUSY] = busy;
    stat[ST_DONE] = (state == DONE);
    stat[ST_ERR]  = err;
  end

  always_comb begin
    word = '0;
    unique case (1'b1)
      bus.rd_addr == ADDR_W'(REG_STATUS): word = stat;
      bus.rd_addr == ADDR_W'(REG_WINNER): word = 32'(win_idx);
      bus.rd_addr == ADDR_W'(REG_WINCNT): word = 32'(win_cnt);
      bus.rd_addr == ADDR_W'(REG_NOUT):   word = 32'(N_OUT);
      default: begin
        for (int i = 0; i < N_OUT; i++) begin
          if (bus.rd_addr == ADDR_W'(REG_CNT_BASE + i))
            word = 32'(counts[i]);
        end
      end
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      bus.rd_valid <= 1'b0;
      bus.rd_data  <= '0;
    end else begin
      bus.rd_valid <= bus.rd_en;
      bus.rd_data  <= bus.rd_en ? word : '0;
    end
  end

endmodule

// File: doc/snn_result_buffer.md
Name: snn_result_buffer

Overview:
Collects output-layer spike events from the SNN core during one inference window and keeps a saturating spike count per output neuron. At window end it scans the counts sequentially to find the winning class, then raises result_ready (the coprocessor-ready flag). It sits directly upstream of the AXI4-Lite read slave, which fetches status, winner and counts through a simple 1-cycle-latency register read port.

Parameters:
N_OUT, 10, number of output neurons / classes (2..64)
CNT_W, 16, spike counter width (≤32)
IDX_W, 8, spike index width from core
ADDR_W, 7, word address width of read port

Ports:
ACLK  in  1  clock
ARESETN  in  1  async reset, active-low
infer_start  in  1  pulse: clear counts, open window
infer_end  in  1  pulse: close window, start argmax
spike_valid  in  1  output spike event valid
spike_idx  in  IDX_W  index of firing output neuron
spike_ready  out  1  event accepted when valid&ready
rd_en  in  1  read request from AXI slave
rd_addr  in  ADDR_W  word address
rd_data  out  32  read data, valid 1 cycle after rd_en
rd_valid  out  1  qualifies rd_data
result_ready  out  1  winner valid (COPROCESSOR_RDY)
result_ack  in  1  host consumed result; clears result_ready
busy  out  1  window open or argmax running

Behaviour:
- Reset: all counts 0, winner 0, win_cnt 0, err 0, state IDLE; spike_ready=0, rd_data=0, rd_valid=0, result_ready=0, busy=0.
- FSM states IDLE, COUNT, SCAN, DONE.
- IDLE/DONE -> COUNT on infer_start: all counts cleared, err cleared, result_ready=0 that same edge.
- COUNT: spike_ready=1. Each accepted event with spike_idx<N_OUT increments counts[idx], saturating at 2^CNT_W-1. spike_idx≥N_OUT: accepted, dropped, err set sticky.
- infer_start in COUNT: restart (clear counts, stay COUNT).
- infer_end in COUNT -> SCAN. A spike accepted in the same cycle is counted.
- SCAN: spike_ready=0. One neuron per cycle, index 0..N_OUT-1. Strict greater-than compare, so ties go to the lowest index. Exactly N_OUT cycles, then -> DONE.
- DONE: result_ready=1 until result_ack (-> IDLE, counts retained) or infer_start (-> COUNT).
- busy=1 in COUNT and SCAN.
- infer_end outside COUNT is ignored. result_ack outside DONE is ignored. infer_start in SCAN is ignored.
- Read port:
  - rd_data registered; rd_valid=1 exactly one cycle after rd_en, else 0.
  - Reads are legal in any state and return live values.
  - Word map:
    - 0: status {28'b0, err, state==DONE, busy, result_ready}
    - 1: winner index
    - 2: winner count
    - 3: N_OUT
    - 4..4+N_OUT-1: counts, zero-extended
    - any other address: 0
- ARESETN low mid-window: immediate return to reset values; no partial result retained.

Decomposition:
- Package snn_result_pkg holds:
  - state enum (IDLE, COUNT, SCAN, DONE)
  - word-offset constants (REG_STATUS=0, REG_WINNER=1, REG_WINCNT=2, REG_NOUT=3, REG_CNT_BASE=4)
  - status bit positions
- One sub-module, snn_result_argmax: sequential scanner taking start/count-in and producing index, max and done. Counter array and read mux stay in the top.

Test Plan:
- Reset, then read addrs 0..3 -> rd_valid one cycle later; data 0,0,0,10; result_ready=0.
- infer_start; spikes idx 3 x5, idx 7 x9, idx 1 x2; infer_end -> after 10 SCAN cycles result_ready=1; winner=7, wincnt=9, count[3]=5 at addr 7.
- Tie: idx 2 x4 and idx 6 x4 -> winner=2.
- Saturation with CNT_W=4: 20 spikes on idx 0 -> count[0]=15.
- Boundary: spike_idx=10 -> err bit set in status, no count changes; spike on same cycle as infer_end -> counted.
- Control and reset:
  - infer_start during DONE clears result_ready and counts.
  - result_ack -> IDLE with counts still readable.
  - ARESETN asserted during COUNT -> all outputs 0, counts 0.
